// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the int_ctrl interrupt controller.
// Contents: register offsets, FSM state encoding, STAT bit positions.
// No logic; imported by int_ctrl and int_prio_enc.
package int_ctrl_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [7:0] OFF_PEND = 8'd0;
  localparam logic [7:0] OFF_MASK = 8'd1;
  localparam logic [7:0] OFF_STAT = 8'd2;
  localparam logic [7:0] OFF_EOI  = 8'd3;
  localparam logic [7:0] OFF_VEC0 = 8'd4;

  // STAT layout: {busy, 4'b0, id[2:0]}
  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_ID_MSB   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Latency: combinational. Backpressure: none.
// Ports: req (N_SRC candidate bits) -> any (some bit set), id (winning index).
module int_prio_enc #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [2:0]       id
);

  always_comb begin
    any = |req;
    id  = 3'd0;
    // Scan high to low so the lowest set index is the last assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: N maskable sources, fixed priority,
// per-source vectors, ack/EOI handshake. Reads combinational; int_req is
// registered, asserting one edge after a candidate is seen in IDLE.
// Backpressure: one request in flight; new events wait in PEND until EOI.
// Ports: clk, reset (sync, active-high); src_i source lines; addr/w_data/
// w_en/r_data/hit data-bus slave; int_req/int_vec/int_ack CPU handshake.
// Build option: define INT_CTRL_LEVEL_EN for level-sensitive sources
// (PEND mirrors registered src_i; W1C and ack do not clear it).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] BASE_ADDR = 8'd236
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_i,
  input  logic [7:0]       addr,
  input  logic [7:0]       w_data,
  input  logic             w_en,
  output logic [7:0]       r_data,
  output logic             hit,
  output logic             int_req,
  output logic [7:0]       int_vec,
  input  logic             int_ack
);

  localparam logic [7:0] WIN_LEN = OFF_VEC0 + 8'(N_SRC);

  int_state_t       state;
  logic [2:0]       id_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mask_nxt;
  logic [N_SRC-1:0] id_oh;
  logic [7:0]       vec [8];
  logic [7:0]       off;
  logic [2:0]       vec_idx;
  logic [7:0]       stat;
  logic             wr;
  logic             wr_mask;
  logic             wr_eoi;
  logic             cand_any;
  logic [2:0]       cand_id;

  // Address decode. Offset wraps to a large value below BASE_ADDR, so the
  // explicit lower-bound compare is what keeps hit clean there.
  assign off     = addr - BASE_ADDR;
  assign hit     = (addr >= BASE_ADDR) && (off < WIN_LEN);
  assign vec_idx = 3'(off - OFF_VEC0);
  assign wr      = w_en && hit;
  assign wr_mask = wr && (off == OFF_MASK);
  assign wr_eoi  = wr && (off == OFF_EOI);

  assign id_oh    = N_SRC'(1) << id_q;
  assign mask_nxt = wr_mask ? w_data[N_SRC-1:0] : mask;

  always_ff @(posedge clk) begin
    if (reset) src_q <= '0;
    else       src_q <= src_i;
  end

`ifdef INT_CTRL_LEVEL_EN
  // Level mode: pending is simply the registered source line.
  assign pend     = src_q;
  assign pend_nxt = src_i;
`else
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;

  assign w1c      = (wr && (off == OFF_PEND)) ? w_data[N_SRC-1:0] : '0;
  assign ack_clr  = (state == ST_REQ && int_ack) ? id_oh : '0;
  // New rising edges OR in last, so a same-cycle event beats any clear.
  assign pend_nxt = (pend & ~w1c & ~ack_clr) | (src_i & ~src_q);

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) mask <= '0;
    else       mask <= mask_nxt;
  end

  // Vector table is sized to the full 3-bit id space; entries at or above
  // N_SRC are never written and stay 0.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (reset)
        vec[k] <= 8'd0;
      else if (k < N_SRC && wr && off == OFF_VEC0 + 8'(k))
        vec[k] <= w_data;
    end
  end

  int_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req (pend & mask),
    .any (cand_any),
    .id  (cand_id)
  );

  // Request FSM. Withdrawal looks at next-cycle PEND/MASK so int_req falls
  // on the same edge that clears the bit; ack takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      id_q    <= 3'd0;
      int_req <= 1'b0;
      int_vec <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cand_any) begin
            id_q    <= cand_id;
            int_vec <= vec[cand_id];
            int_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= ST_SERVICE;
          end else if ((pend_nxt & id_oh) == '0 || (mask_nxt & id_oh) == '0) begin
            int_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) state <= ST_IDLE;
        end
        default: begin
          int_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stat                    = 8'd0;
    stat[STAT_BUSY_BIT]     = (state == ST_SERVICE);
    stat[STAT_ID_MSB:0]     = id_q;
  end

  always_comb begin
    r_data = 8'd0;
    if (hit) begin
      case (off)
        OFF_PEND: r_data = 8'(pend);
        OFF_MASK: r_data = 8'(mask);
        OFF_STAT: r_data = stat;
        OFF_EOI:  r_data = 8'd0;
        default:  r_data = vec[vec_idx];
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (N_SRC=4, BASE_ADDR=236).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_int_ctrl;

  localparam logic [7:0] A_PEND = 8'd236;
  localparam logic [7:0] A_MASK = 8'd237;
  localparam logic [7:0] A_STAT = 8'd238;
  localparam logic [7:0] A_EOI  = 8'd239;
  localparam logic [7:0] A_VEC0 = 8'd240;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src_i;
  logic [7:0] addr;
  logic [7:0] w_data;
  logic       w_en;
  logic [7:0] r_data;
  logic       hit;
  logic       int_req;
  logic [7:0] int_vec;
  logic       int_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_ctrl #(.N_SRC(4), .BASE_ADDR(8'd236)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_i   (src_i),
    .addr    (addr),
    .w_data  (w_data),
    .w_en    (w_en),
    .r_data  (r_data),
    .hit     (hit),
    .int_req (int_req),
    .int_vec (int_vec),
    .int_ack (int_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, {24'd0, r_data}, {24'd0, exp});
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] s);
    src_i = s;
    tick();
    src_i = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_i = 4'd0; addr = 8'd0; w_data = 8'd0; w_en = 1'b0; int_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and address window
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    chk("rst_int_vec", {24'd0, int_vec}, 32'd0);
    rd_chk("rst_pend", A_PEND, 8'h00);
    rd_chk("rst_mask", A_MASK, 8'h00);
    rd_chk("rst_stat", A_STAT, 8'h00);
    rd_chk("rst_vec0", A_VEC0, 8'h00);
    addr = 8'd236; #1; chk("hit_lo", {31'd0, hit}, 32'd1);
    addr = 8'd243; #1; chk("hit_hi", {31'd0, hit}, 32'd1);
    addr = 8'd235; #1; chk("hit_below", {31'd0, hit}, 32'd0);
    chk("rdata_miss", {24'd0, r_data}, 32'd0);
    addr = 8'd244; #1; chk("hit_above", {31'd0, hit}, 32'd0);

`ifdef INT_CTRL_LEVEL_EN
    // Level mode: held source re-requests after EOI
    wr(A_MASK, 8'h01);
    wr(A_VEC0, 8'h40);
    src_i = 4'b0001;
    tick();
    chk("lvl_req_early", {31'd0, int_req}, 32'd0);
    tick();
    chk("lvl_req", {31'd0, int_req}, 32'd1);
    chk("lvl_vec", {24'd0, int_vec}, 32'h40);
    ack();
    rd_chk("lvl_stat_svc", A_STAT, 8'h80);
    rd_chk("lvl_pend_held", A_PEND, 8'h01);
    wr(A_EOI, 8'h00);
    chk("lvl_idle_after_eoi", {31'd0, int_req}, 32'd0);
    tick();
    chk("lvl_rereq", {31'd0, int_req}, 32'd1);
    ack();
    src_i = 4'd0;
    tick();
    wr(A_EOI, 8'h00);
    tick(); tick();
    chk("lvl_stays_idle", {31'd0, int_req}, 32'd0);
    rd_chk("lvl_stat_idle", A_STAT, 8'h00);
    rd_chk("lvl_pend_clear", A_PEND, 8'h00);
`else
    // Single source: capture, request, ack, EOI
    wr(A_MASK, 8'h01);
    wr(A_VEC0, 8'h40);
    pulse_src(4'b0001);
    chk("t1_req_early", {31'd0, int_req}, 32'd0);
    rd_chk("t1_pend_set", A_PEND, 8'h01);
    tick();
    chk("t1_req", {31'd0, int_req}, 32'd1);
    chk("t1_vec", {24'd0, int_vec}, 32'h40);
    wr(A_VEC0, 8'h41);
    chk("t1_vec_latched", {24'd0, int_vec}, 32'h40);
    rd_chk("t1_vec0_rd", A_VEC0, 8'h41);
    ack();
    chk("t1_req_after_ack", {31'd0, int_req}, 32'd0);
    rd_chk("t1_pend_after_ack", A_PEND, 8'h00);
    rd_chk("t1_stat_svc", A_STAT, 8'h80);
    rd_chk("t1_eoi_rd", A_EOI, 8'h00);
    wr(A_EOI, 8'h00);
    rd_chk("t1_stat_idle", A_STAT, 8'h00);
    tick();
    chk("t1_no_rereq", {31'd0, int_req}, 32'd0);

    // Two sources together: lower index first
    wr(A_MASK, 8'h0A);
    wr(A_VEC0 + 8'd1, 8'h50);
    wr(A_VEC0 + 8'd3, 8'h70);
    pulse_src(4'b1010);
    tick();
    chk("t2_req", {31'd0, int_req}, 32'd1);
    chk("t2_vec_first", {24'd0, int_vec}, 32'h50);
    rd_chk("t2_stat_req", A_STAT, 8'h01);
    rd_chk("t2_pend", A_PEND, 8'h0A);
    ack();
    rd_chk("t2_pend_after_ack", A_PEND, 8'h08);
    rd_chk("t2_stat_svc", A_STAT, 8'h81);
    wr(A_EOI, 8'h00);
    chk("t2_idle_after_eoi", {31'd0, int_req}, 32'd0);
    tick();
    chk("t2_rereq", {31'd0, int_req}, 32'd1);
    chk("t2_vec_second", {24'd0, int_vec}, 32'h70);
    rd_chk("t2_stat_req3", A_STAT, 8'h03);
    ack();
    wr(A_EOI, 8'h00);
    rd_chk("t2_pend_empty", A_PEND, 8'h00);

    // Masked pending source, then unmask
    wr(A_MASK, 8'h00);
    pulse_src(4'b0100);
    tick(); tick();
    chk("t3_masked_noreq", {31'd0, int_req}, 32'd0);
    rd_chk("t3_pend", A_PEND, 8'h04);
    wr(A_MASK, 8'h04);
    chk("t3_req_not_yet", {31'd0, int_req}, 32'd0);
    tick();
    chk("t3_req", {31'd0, int_req}, 32'd1);
    chk("t3_vec", {24'd0, int_vec}, 32'h00);
    ack();
    wr(A_EOI, 8'h00);

    // Withdraw by W1C during REQ
    wr(A_MASK, 8'h01);
    pulse_src(4'b0001);
    tick();
    chk("t4_req", {31'd0, int_req}, 32'd1);
    wr(A_PEND, 8'h01);
    chk("t4_withdrawn", {31'd0, int_req}, 32'd0);
    rd_chk("t4_pend_cleared", A_PEND, 8'h00);
    rd_chk("t4_stat_idle", A_STAT, 8'h00);
    tick();
    chk("t4_stays_idle", {31'd0, int_req}, 32'd0);

    // Same-cycle edge and W1C: set wins
    addr = A_PEND; w_data = 8'h01; w_en = 1'b1; src_i = 4'b0001;
    tick();
    w_en = 1'b0; src_i = 4'd0;
    rd_chk("t4_set_wins", A_PEND, 8'h01);
    tick();
    chk("t4_req_again", {31'd0, int_req}, 32'd1);
    ack();
    rd_chk("t4_stat_svc", A_STAT, 8'h80);

    // Reset during SERVICE
    do_reset();
    rd_chk("t5_stat", A_STAT, 8'h00);
    rd_chk("t5_pend", A_PEND, 8'h00);
    rd_chk("t5_mask", A_MASK, 8'h00);
    chk("t5_int_req", {31'd0, int_req}, 32'd0);
    chk("t5_int_vec", {24'd0, int_vec}, 32'h00);

    // ack and EOI in IDLE are ignored
    wr(A_MASK, 8'h01);
    ack();
    wr(A_EOI, 8'h00);
    rd_chk("t5_idle_stat", A_STAT, 8'h00);
    rd_chk("t5_idle_mask", A_MASK, 8'h01);
    chk("t5_idle_req", {31'd0, int_req}, 32'd0);

    // Reset mid-request
    wr(A_VEC0, 8'h22);
    pulse_src(4'b0001);
    tick();
    chk("t6_req", {31'd0, int_req}, 32'd1);
    chk("t6_vec", {24'd0, int_vec}, 32'h22);
    do_reset();
    chk("t6_req_dropped", {31'd0, int_req}, 32'd0);
    rd_chk("t6_vec0_cleared", A_VEC0, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
